pipe_cla_add: RTL and testbench
===============================

// Module: pipe_cla_add
// PURPOSE
//  Parametrised, pipelined carry-lookahead add/subtract unit with a valid/ready handshake.
//  Next generation of the FIR datapath's fixed 32b adder:
//   - configurable width, lookahead block size and pipeline depth
//   - subtract, carry-in, carry-out, signed overflow and optional saturation
//  Sits between the multiplier array and the accumulator; also usable as a standalone accumulate adder.
// PARAMETERS
//  WIDTH   32  operand/result width; must be a multiple of BLK
//  BLK     4   bits per lookahead block
//  STAGES  2   pipeline register stages, 1..WIDTH/BLK; equals latency in cycles
//  SAT     0   1: saturate s to signed max/min on overflow; 0: wrap
// PORTS
//  clk        in   1      clock; all registers update on the falling edge, as in the rest of the datapath
//  rstn       in   1      synchronous active-low reset
//  in_valid   in   1      a/b/cin/sub are valid this cycle
//  in_ready   out  1      unit accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (borrow-in when sub=1)
//  sub        in   1      1: compute a-b-cin; 0: compute a+b+cin
//  out_valid  out  1      s/cout/ovf are valid
//  out_ready  in   1      downstream accepts output
//  s          out  WIDTH  result
//  cout       out  1      unsigned carry-out of the final block (pre-saturation)
//  ovf        out  1      signed overflow flag
// BEHAVIOUR
//  - Reset (rstn=0 at a clk edge): all stage valid bits, out_valid, s, cout and ovf become 0.
//    Reset mid-operation discards all in-flight data. in_ready=1 from the first cycle after reset.
//  - Operand prep: eb = sub ? ~b : b; ec = cin ^ sub. Then a-b uses cin=0, and a-b-1 uses cin=1.
//  - Blocks: NB = WIDTH/BLK. Stage k computes blocks [k*NB/STAGES, (k+1)*NB/STAGES) (integer division).
//    Blocks ripple carry within a stage.
//  - Between stages register the following: the stage carry, the completed low sum bits, the not-yet-used high operand bits,
//    the sub flag and the valid bit (skew registers).
//  - Latency: a transfer accepted at edge n appears on outputs after edge n+STAGES-1 (STAGES=1: registered output, one edge).
//  - Handshake: en = out_ready | ~out_valid; in_ready = en.
//    - When en=1, every stage shifts. A transfer happens when in_valid & in_ready.
//    - When en=0, every stage holds, and s/cout/ovf stay stable while out_valid=1.
//    - Bubbles are not collapsed.
//    - in_valid=0 while en=1 inserts a bubble: stage 0 valid becomes 0 and its data is don't-care.
//  - Simultaneous output take and input accept: both happen in the same cycle; full throughput is one result per cycle.
//  - ovf = carry-into-MSB XOR carry-out-of-MSB, computed on the eb/ec-adjusted add.
//  - SAT=1 and ovf=1: s = raw MSB ? {1'b0,{WIDTH-1{1'b1}}} : {1'b1,{WIDTH-1{1'b0}}}.
//    cout and ovf still report the raw values.
//  - Wrap-around: SAT=0 gives the result modulo 2^WIDTH.
//  - Parameter violations (WIDTH%BLK!=0, STAGES>NB, STAGES<1) stop elaboration via a generate-time $error.
// STRUCTURE
//  - Package add_pkg holds:
//    - localparam functions nblk(WIDTH,BLK) and stage_lo/stage_hi(k,NB,STAGES)
//    - the saturation constants, as functions of width
//  - One sub-module, cla_blk #(BLK): a, b [BLK], ci -> s [BLK], co, plus c_msb (carry into the top bit, used for ovf).
//    It is instantiated NB times through generate.
//  - The top level holds the skew/pipeline registers and the handshake only.
// TESTING (default params unless noted; compare every output with a reference model)
//  1. Reset mid-stream: 3 inputs in flight, rstn=0 for one edge -> out_valid=0, s=0; no stale result ever emerges.
//  2. Add/sub: a=32'h0000_FFFF, b=1, cin=0, sub=0 -> s=32'h0001_0000, cout=0, ovf=0, after exactly 2 edges.
//     Then a=5, b=7, sub=1 -> s=32'hFFFF_FFFE, cout=0.
//  3. Overflow: a=32'h7FFF_FFFF, b=1.
//     - SAT=0 -> s=32'h8000_0000, ovf=1.
//     - SAT=1 -> s=32'h7FFF_FFFF, ovf=1.
//     a=32'h8000_0000, b=1, sub=1, SAT=1 -> s=32'h8000_0000, ovf=1.
//  4. Backpressure: stream 10 random pairs; hold out_ready=0 for 4 cycles mid-stream.
//     -> in_ready=0 while out_valid=1; outputs stable; no loss or duplication; order kept.
//  5. Carry chain: a=32'hFFFF_FFFF, b=0, cin=1 -> s=0, cout=1.
//     Repeat for (WIDTH,BLK,STAGES) = (16,4,4), (64,8,3) and (8,2,1).
//  6. Throughput: in_valid=1 and out_ready=1 for 100 cycles -> 100 results in 100 consecutive cycles after the fill latency.

Source files
------------

// File: rtl/add_pkg.sv
// Shared sizing helpers and saturation constants for the pipelined lookahead adder.
package add_pkg;

    localparam int SAT_MAXW = 256;

    function automatic int nblk(input int width, input int blk);
        return width / blk;
    endfunction

    function automatic int stage_lo(input int k, input int nb, input int stages);
        return (k * nb) / stages;
    endfunction

    function automatic int stage_hi(input int k, input int nb, input int stages);
        return ((k + 1) * nb) / stages;
    endfunction

    // Most negative signed value of the given width, zero-extended to SAT_MAXW.
    function automatic logic [SAT_MAXW-1:0] sat_min_w(input int width);
        return {{(SAT_MAXW-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

    function automatic logic [SAT_MAXW-1:0] sat_max_w(input int width);
        return sat_min_w(width) - {{(SAT_MAXW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/cla_blk.sv
// One carry-lookahead block: sum, carry-out and the carry into its top bit.
module cla_blk #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [BLK-1:0] w_g;
    logic [BLK-1:0] w_p;
    logic [BLK:0]   w_c;
    logic           w_prop;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is a flat OR of generate terms gated by propagate runs, never a ripple.
    always_comb begin
        w_c    = {(BLK+1){1'b0}};
        w_prop = 1'b0;
        w_c[0] = ci;
        for (int i = 0; i < BLK; i++) begin
            w_prop     = w_p[i];
            w_c[i+1]   = w_g[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_c[i+1] = w_c[i+1] | (w_prop & w_g[j]);
                w_prop   = w_prop & w_p[j];
            end
            w_c[i+1] = w_c[i+1] | (w_prop & ci);
        end
    end

    assign s     = w_p ^ w_c[BLK-1:0];
    assign co    = w_c[BLK];
    assign c_msb = w_c[BLK-1];

endmodule

// File: rtl/pipe_cla_add.sv
// Pipelined carry-lookahead add/subtract with valid/ready handshake.
// Registers update on the falling clock edge to match the surrounding datapath.
module pipe_cla_add
    import add_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2,
    parameter int SAT    = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NB   = nblk(WIDTH, BLK);
    localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

    localparam logic [SAT_MAXW-1:0] SAT_MAX_L = sat_max_w(WIDTH);
    localparam logic [SAT_MAXW-1:0] SAT_MIN_L = sat_min_w(WIDTH);
    localparam logic [WIDTH-1:0]    SAT_MAX   = SAT_MAX_L[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    SAT_MIN   = SAT_MIN_L[WIDTH-1:0];

    if (((WIDTH % BLK) != 0) || (STAGES < 1) || (STAGES > (WIDTH / BLK))) begin : g_bad_params
        $error("pipe_cla_add: illegal WIDTH/BLK/STAGES combination");
    end

    logic             w_en;
    logic [WIDTH-1:0] w_s;
    logic [NB-1:0]    w_co;
    logic             w_c_msb;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;

    // Per-stage operands as seen by that stage's blocks.
    logic [WIDTH-1:0] w_src_a     [STAGES];
    logic [WIDTH-1:0] w_src_b     [STAGES];
    logic [WIDTH-1:0] w_src_sum   [STAGES];
    logic             w_src_c     [STAGES];
    logic             w_src_sub   [STAGES];
    logic             w_src_valid [STAGES];
    logic [WIDTH-1:0] w_acc       [STAGES];
    logic             w_stage_co  [STAGES];

    logic [WIDTH-1:0] r_a     [NREG];
    logic [WIDTH-1:0] r_b     [NREG];
    logic [WIDTH-1:0] r_sum   [NREG];
    logic             r_carry [NREG];
    logic             r_sub   [NREG];
    logic             r_valid [NREG];

    assign w_en     = out_ready | ~out_valid;
    assign in_ready = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = stage_lo(k, NB, STAGES);
        localparam int HI = stage_hi(k, NB, STAGES);
        localparam logic [WIDTH-1:0] DONE_MASK = ~({WIDTH{1'b1}} << (LO * BLK));

        if (k == 0) begin : g_in
            assign w_src_a[k]     = a;
            assign w_src_b[k]     = b;
            assign w_src_sum[k]   = {WIDTH{1'b0}};
            assign w_src_c[k]     = cin ^ sub;
            assign w_src_sub[k]   = sub;
            assign w_src_valid[k] = in_valid;
        end else begin : g_skew
            assign w_src_a[k]     = r_a[k-1];
            assign w_src_b[k]     = r_b[k-1];
            assign w_src_sum[k]   = r_sum[k-1];
            assign w_src_c[k]     = r_carry[k-1];
            assign w_src_sub[k]   = r_sub[k-1];
            assign w_src_valid[k] = r_valid[k-1];
        end

        for (genvar j = LO; j < HI; j++) begin : g_blk
            logic           w_ci;
            logic [BLK-1:0] w_eb;

            if (j == LO) begin : g_first
                assign w_ci = w_src_c[k];
            end else begin : g_chain
                assign w_ci = w_co[j-1];
            end

            assign w_eb = w_src_sub[k] ? ~w_src_b[k][j*BLK +: BLK] : w_src_b[k][j*BLK +: BLK];

            if (j == NB - 1) begin : g_top
                cla_blk #(.BLK(BLK)) u_cla (
                    .a     (w_src_a[k][j*BLK +: BLK]),
                    .b     (w_eb),
                    .ci    (w_ci),
                    .s     (w_s[j*BLK +: BLK]),
                    .co    (w_co[j]),
                    .c_msb (w_c_msb)
                );
            end else begin : g_mid
                cla_blk #(.BLK(BLK)) u_cla (
                    .a     (w_src_a[k][j*BLK +: BLK]),
                    .b     (w_eb),
                    .ci    (w_ci),
                    .s     (w_s[j*BLK +: BLK]),
                    .co    (w_co[j]),
                    .c_msb ()
                );
            end
        end

        // Low bits finished by earlier stages, this stage's blocks on top.
        assign w_acc[k]      = (w_src_sum[k] & DONE_MASK) | (w_s & ~DONE_MASK);
        assign w_stage_co[k] = w_co[HI-1];
    end

    if (STAGES > 1) begin : g_pipe
        // Skew registers between stages; all hold together when the output is stalled.
        always_ff @(negedge clk) begin
            if (!rstn) begin
                for (int k = 0; k < NREG; k++) begin
                    r_valid[k] <= 1'b0;
                    r_carry[k] <= 1'b0;
                    r_sub[k]   <= 1'b0;
                    r_a[k]     <= {WIDTH{1'b0}};
                    r_b[k]     <= {WIDTH{1'b0}};
                    r_sum[k]   <= {WIDTH{1'b0}};
                end
            end else if (w_en) begin
                for (int k = 0; k < NREG; k++) begin
                    r_valid[k] <= w_src_valid[k];
                    r_carry[k] <= w_stage_co[k];
                    r_sub[k]   <= w_src_sub[k];
                    r_a[k]     <= w_src_a[k];
                    r_b[k]     <= w_src_b[k];
                    r_sum[k]   <= w_acc[k];
                end
            end
        end
    end

    // Overflow from the carries around the MSB, then optional clamp.
    always_comb begin
        w_ovf = w_c_msb ^ w_co[NB-1];
        w_res = w_acc[STAGES-1];
        if ((SAT != 32'sd0) && w_ovf) begin
            w_res = w_acc[STAGES-1][WIDTH-1] ? SAT_MAX : SAT_MIN;
        end else begin
            w_res = w_acc[STAGES-1];
        end
    end

    // Final stage result register.
    always_ff @(negedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            s         <= {WIDTH{1'b0}};
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (w_en) begin
            out_valid <= w_src_valid[STAGES-1];
            s         <= w_res;
            cout      <= w_stage_co[STAGES-1];
            ovf       <= w_ovf;
        end
    end

endmodule

// File: tb/tb_pipe_cla_add.sv
// Drives five adder configurations in lockstep and checks each against an arithmetic model.
module tb_pipe_cla_add;

    logic        clk = 1'b0;
    logic        rstn, in_valid, cin, sub, out_ready;
    logic [63:0] a_in, b_in;
    logic [4:0]  ir, ov, co, of;
    logic [31:0] s0, s1;
    logic [15:0] s2;
    logic [63:0] s3;
    logic [7:0]  s4;
    logic [63:0] obs_s [5];

    logic [63:0] e_s   [5][64];
    logic        e_c   [5][64];
    logic        e_v   [5][64];
    int          e_cyc [5][64];
    logic        e_lat [5][64];
    int          wp [5];
    int          rp [5];
    int          takes [5];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    pipe_cla_add #(.WIDTH(32), .BLK(4), .STAGES(2), .SAT(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir[0]), .a(a_in[31:0]), .b(b_in[31:0]),
        .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready), .s(s0), .cout(co[0]), .ovf(of[0]));
    pipe_cla_add #(.WIDTH(32), .BLK(4), .STAGES(2), .SAT(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir[1]), .a(a_in[31:0]), .b(b_in[31:0]),
        .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready), .s(s1), .cout(co[1]), .ovf(of[1]));
    pipe_cla_add #(.WIDTH(16), .BLK(4), .STAGES(4), .SAT(0)) u_dut2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir[2]), .a(a_in[15:0]), .b(b_in[15:0]),
        .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready), .s(s2), .cout(co[2]), .ovf(of[2]));
    pipe_cla_add #(.WIDTH(64), .BLK(8), .STAGES(3), .SAT(0)) u_dut3 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir[3]), .a(a_in), .b(b_in),
        .cin(cin), .sub(sub), .out_valid(ov[3]), .out_ready(out_ready), .s(s3), .cout(co[3]), .ovf(of[3]));
    pipe_cla_add #(.WIDTH(8), .BLK(2), .STAGES(1), .SAT(0)) u_dut4 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir[4]), .a(a_in[7:0]), .b(b_in[7:0]),
        .cin(cin), .sub(sub), .out_valid(ov[4]), .out_ready(out_ready), .s(s4), .cout(co[4]), .ovf(of[4]));

    always_comb begin
        obs_s[0] = {32'd0, s0};
        obs_s[1] = {32'd0, s1};
        obs_s[2] = {48'd0, s2};
        obs_s[3] = s3;
        obs_s[4] = {56'd0, s4};
    end

    function automatic int w_of(input int d);
        case (d)
            0, 1:    return 32;
            2:       return 16;
            3:       return 64;
            default: return 8;
        endcase
    endfunction

    function automatic int st_of(input int d);
        case (d)
            0, 1:    return 2;
            2:       return 4;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    // Reference: plain integer arithmetic on 128-bit signed values.
    function automatic void ref_add(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                                    input logic sb, input int w, input logic sat,
                                    output logic [63:0] rs, output logic rc, output logic rv);
        logic signed [127:0] one, m, half, ua, ub, c, ur, sa, sbv, sr, tmp;
        one  = 128'sd1;
        m    = (one <<< w) - one;
        half = one <<< (w - 1);
        ua   = $signed({64'd0, av}) & m;
        ub   = $signed({64'd0, bv}) & m;
        c    = ci ? one : 128'sd0;
        if (sb) begin
            ur = ua - ub - c;
            rc = (ur >= 128'sd0);
        end else begin
            ur = ua + ub + c;
            rc = (ur > m);
        end
        tmp = ur & m;
        rs  = tmp[63:0];
        sa  = (ua >= half) ? ua - (one <<< w) : ua;
        sbv = (ub >= half) ? ub - (one <<< w) : ub;
        sr  = sb ? sa - sbv - c : sa + sbv + c;
        rv  = (sr >= half) || (sr < -half);
        if (sat && rv) begin
            tmp = (sr > 128'sd0) ? half - one : (-half) & m;
            rs  = tmp[63:0];
        end
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_cycle(input logic iv, input logic [63:0] av, input logic [63:0] bv,
                               input logic ci, input logic sb, input logic ordy, input logic lat);
        logic [63:0] rs;
        logic        rc, rv;
        int          idx;
        in_valid  = iv;
        a_in      = av;
        b_in      = bv;
        cin       = ci;
        sub       = sb;
        out_ready = ordy;
        #1;
        for (int d = 0; d < 5; d++) begin
            check_eq($sformatf("u%0d in_ready", d), {63'd0, ir[d]}, {63'd0, ordy | ~ov[d]});
            if (ov[d]) begin
                if (wp[d] == rp[d]) begin
                    check_eq($sformatf("u%0d spurious out_valid", d), {63'd0, ov[d]}, 64'd0);
                end else begin
                    idx = rp[d] % 64;
                    check_eq($sformatf("u%0d s", d), obs_s[d], e_s[d][idx]);
                    check_eq($sformatf("u%0d cout", d), {63'd0, co[d]}, {63'd0, e_c[d][idx]});
                    check_eq($sformatf("u%0d ovf", d), {63'd0, of[d]}, {63'd0, e_v[d][idx]});
                    if (ordy) begin
                        if (e_lat[d][idx])
                            check_eq($sformatf("u%0d latency", d), 64'(cyc - e_cyc[d][idx]), 64'(st_of(d)));
                        rp[d]++;
                        takes[d]++;
                    end
                end
            end
            if (iv && ir[d]) begin
                ref_add(av, bv, ci, sb, w_of(d), (d == 1), rs, rc, rv);
                idx            = wp[d] % 64;
                e_s[d][idx]    = rs;
                e_c[d][idx]    = rc;
                e_v[d][idx]    = rv;
                e_cyc[d][idx]  = cyc;
                e_lat[d][idx]  = lat;
                wp[d]++;
            end
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_cycle();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        cyc++;
        rstn = 1'b1;
        for (int d = 0; d < 5; d++) begin
            check_eq($sformatf("u%0d rst out_valid", d), {63'd0, ov[d]}, 64'd0);
            check_eq($sformatf("u%0d rst s", d), obs_s[d], 64'd0);
            check_eq($sformatf("u%0d rst cout", d), {63'd0, co[d]}, 64'd0);
            check_eq($sformatf("u%0d rst ovf", d), {63'd0, of[d]}, 64'd0);
            check_eq($sformatf("u%0d rst in_ready", d), {63'd0, ir[d]}, 64'd1);
            rp[d] = wp[d];
        end
    endtask

    task automatic drain();
        int busy;
        for (int i = 0; i < 60; i++) begin
            busy = 0;
            for (int d = 0; d < 5; d++) busy += wp[d] - rp[d];
            if (busy == 0) break;
            drive_cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        for (int d = 0; d < 5; d++)
            check_eq($sformatf("u%0d pending after drain", d), 64'(wp[d] - rp[d]), 64'd0);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'd0;
            2:       return 64'h8000_0000_8000_8080;
            3:       return 64'h7FFF_FFFF_7FFF_7F7F;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap [5];
        rstn = 1'b0; in_valid = 1'b0; a_in = 64'd0; b_in = 64'd0;
        cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        for (int d = 0; d < 5; d++) begin
            wp[d] = 0; rp[d] = 0; takes[d] = 0;
        end
        @(posedge clk);
        #1;
        reset_cycle();
        reset_cycle();

        // Basic add/sub with exact latency
        drive_cycle(1'b1, 64'h0000_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b1, 64'd5, 64'd7, 1'b0, 1'b1, 1'b1, 1'b1);
        drain();

        // Overflow, saturation and the full carry chain
        drive_cycle(1'b1, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b1, 64'h8000_0000, 64'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        drive_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b1, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        drain();

        // Reset with results in flight: nothing stale may appear afterwards
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        reset_cycle();
        for (int i = 0; i < 6; i++)
            drive_cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // Backpressure in the middle of a stream
        for (int i = 0; i < 14; i++)
            drive_cycle(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        !(i >= 4 && i < 8), 1'b0);
        drain();

        // Full throughput
        for (int d = 0; d < 5; d++) snap[d] = takes[d];
        for (int i = 0; i < 100; i++)
            drive_cycle(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        drain();
        for (int d = 0; d < 5; d++)
            check_eq($sformatf("u%0d throughput count", d), 64'(takes[d] - snap[d]), 64'd100);

        // Random valid/ready traffic
        for (int i = 0; i < 200; i++)
            drive_cycle($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
